regfile_sb: RTL

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 102 ++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// Register file with combinational bypass, a busy scoreboard for long-latency
// writebacks and a sequential clear engine that zeroes one register per cycle.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            lw_en,
  input  logic [AW-1:0]   lw_addr,
  input  logic [XLEN-1:0] lw_data,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
  input  logic            clr_req,
  output logic            clr_busy
);

  typedef enum logic {IDLE, CLR} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   cnt_reg;
  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy_reg;
  logic            in_clr;

  assign in_clr   = (state_reg == CLR);
  assign clr_busy = in_clr;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (clr_req) state_next = CLR;
      CLR:     if (cnt_reg == AW'(NREG - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (in_clr)
        cnt_reg <= cnt_reg + AW'(1);
      else if (clr_req)
        cnt_reg <= AW'(1);
    end
  end

  // Port A is assigned last so it wins a same-address collision with port B;
  // likewise an issue set is assigned after the completion clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      busy_reg <= '0;
    end else if (in_clr) begin
      regs[cnt_reg]     <= '0;
      busy_reg[cnt_reg] <= 1'b0;
    end else begin
      if (lw_en && lw_addr != '0) regs[lw_addr] <= lw_data;
      if (wb_en && wb_addr != '0) regs[wb_addr] <= wb_data;
      if (lw_en) busy_reg[lw_addr] <= 1'b0;
      if (iss_en && iss_addr != '0) busy_reg[iss_addr] <= 1'b1;
    end
  end

  always_comb begin
    rs1_data = regs[rs1_addr];
    if (rs1_addr == '0)
      rs1_data = '0;
    else if (!in_clr && wb_en && wb_addr == rs1_addr)
      rs1_data = wb_data;
    else if (!in_clr && lw_en && lw_addr == rs1_addr)
      rs1_data = lw_data;
  end

  always_comb begin
    rs2_data = regs[rs2_addr];
    if (rs2_addr == '0)
      rs2_data = '0;
    else if (!in_clr && wb_en && wb_addr == rs2_addr)
      rs2_data = wb_data;
    else if (!in_clr && lw_en && lw_addr == rs2_addr)
      rs2_data = lw_data;
  end

  // A completing long-latency write hides the busy bit in the same cycle.
  assign rs1_busy = busy_reg[rs1_addr] & ~(!in_clr & lw_en & (lw_addr == rs1_addr));
  assign rs2_busy = busy_reg[rs2_addr] & ~(!in_clr & lw_en & (lw_addr == rs2_addr));

endmodule
